// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: control-field layout,
// bubble constants and occupancy encoding.
package pipe_pkg;

    localparam int CTRL_W_DEF = 17;
    localparam int DATA_W_DEF = 32;

    // Control-field slices: EX 11:0, MEM 13:12, WB 16:14
    localparam int EX_LSB  = 0;
    localparam int EX_MSB  = 11;
    localparam int MEM_LSB = 12;
    localparam int MEM_MSB = 13;
    localparam int WB_LSB  = 14;
    localparam int WB_MSB  = 16;

    localparam logic [CTRL_W_DEF-1:0] BUBBLE_NOP = '0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One loadable control+data register. Clearing drops the control field to the
// bubble value but keeps the data field so out_data never toggles on a kill.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W      = CTRL_W_DEF,
    parameter int                 DATA_W      = DATA_W_DEF,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_NOP)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              ld,
    input  logic              clr,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            ctrl_d = BUBBLE_CTRL;
        end else if (ld) begin
            ctrl_d = in_ctrl;
            data_d = in_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            ctrl_q <= BUBBLE_CTRL;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_ctrl = ctrl_q;
    assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register with optional 2-entry skid.
//   state     | meaning
//   OCC_EMPTY | no entry held, out_valid=0, out_ctrl=bubble
//   OCC_ONE   | head entry in main register
//   OCC_TWO   | head in main, second entry in skid (SKID=1 only), in_ready=0
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 CTRL_W      = CTRL_W_DEF,
    parameter int                 DATA_W      = DATA_W_DEF,
    parameter int                 SKID        = 1,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = CTRL_W'(BUBBLE_NOP)
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_e state_q, state_d;
    logic in_ready_q, in_ready_d;
    logic accept, drain;
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_src_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_src_data;

    assign out_valid = (state_q != OCC_EMPTY);
    assign in_ready  = (SKID != 0) ? in_ready_q : (~out_valid | out_ready);

    // An offer in a flush cycle is dropped even when in_ready is high.
    assign accept = in_valid & in_ready & ~flush;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = OCC_EMPTY;
        end else begin
            unique case (state_q)
                OCC_EMPTY: if (accept) state_d = OCC_ONE;
                OCC_ONE: begin
                    if (accept && !drain && (SKID != 0)) state_d = OCC_TWO;
                    else if (!accept && drain)           state_d = OCC_EMPTY;
                end
                OCC_TWO:   if (drain) state_d = OCC_ONE;
                default:   state_d = OCC_EMPTY;
            endcase
        end
        in_ready_d = (state_d != OCC_TWO);
    end

    always_comb begin
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                OCC_EMPTY: main_load = accept;
                OCC_ONE: begin
                    main_load  = accept & drain;
                    main_clear = ~accept & drain;
                    skid_load  = accept & ~drain;
                end
                OCC_TWO: begin
                    main_load      = drain;
                    main_from_skid = 1'b1;
                    skid_clear     = drain;
                end
                default: main_clear = 1'b1;
            endcase
        end
    end

    assign main_src_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
    assign main_src_data = main_from_skid ? skid_data : in_data;

    pipe_entry_reg #(
        .CTRL_W      (CTRL_W),
        .DATA_W      (DATA_W),
        .BUBBLE_CTRL (BUBBLE_CTRL)
    ) u_main (
        .sysclk  (sysclk),
        .reset   (reset),
        .ld      (main_load),
        .clr     (main_clear),
        .in_ctrl (main_src_ctrl),
        .in_data (main_src_data),
        .q_ctrl  (main_ctrl),
        .q_data  (main_data)
    );

    if (SKID != 0) begin : g_skid
        pipe_entry_reg #(
            .CTRL_W      (CTRL_W),
            .DATA_W      (DATA_W),
            .BUBBLE_CTRL (BUBBLE_CTRL)
        ) u_skid (
            .sysclk  (sysclk),
            .reset   (reset),
            .ld      (skid_load),
            .clr     (skid_clear),
            .in_ctrl (in_ctrl),
            .in_data (in_data),
            .q_ctrl  (skid_ctrl),
            .q_data  (skid_data)
        );
    end else begin : g_no_skid
        assign skid_ctrl = BUBBLE_CTRL;
        assign skid_data = '0;
    end

    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;
    assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share one stimulus
// stream, each tracked by a queue model and checked every cycle.
module tb_pipe_stage_reg;

    localparam int CW = 17;
    localparam int DW = 32;
    localparam logic [CW-1:0] BUB1 = 17'h1ABCD;
    localparam logic [CW-1:0] BUB0 = 17'h00000;

    logic sysclk = 1'b0;
    logic reset, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    always #5 sysclk = ~sysclk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .BUBBLE_CTRL(BUB1)) dut1 (
        .sysclk(sysclk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_ctrl(out_ctrl1),
        .out_data(out_data1), .occupancy(occ1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .BUBBLE_CTRL(BUB0)) dut0 (
        .sysclk(sysclk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0),
        .out_data(out_data0), .occupancy(occ0)
    );

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] last0 = '0;
    int            n_vec  = 0;
    int            n_miss = 0;
    bit            chk_en = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of accepted entries, capacity 2 (skid) or 1 with pass-through ready.
    always @(posedge sysclk) begin
        bit acc1, drn1, acc0, drn0;
        if (reset) begin
            q1.delete(); q0.delete();
            last1 = '0;  last0 = '0;
        end else if (flush) begin
            q1.delete(); q0.delete();
        end else begin
            acc1 = in_valid && (q1.size() < 2);
            drn1 = (q1.size() > 0) && out_ready;
            acc0 = in_valid && ((q0.size() == 0) || out_ready);
            drn0 = (q0.size() > 0) && out_ready;
            if (drn1) void'(q1.pop_front());
            if (acc1) q1.push_back(ent_t'({in_ctrl, in_data}));
            if (drn0) void'(q0.pop_front());
            if (acc0) q0.push_back(ent_t'({in_ctrl, in_data}));
        end
        if (q1.size() > 0) last1 = q1[0].d;
        if (q0.size() > 0) last0 = q0[0].d;
    end

    always @(negedge sysclk) begin
        if (chk_en) begin
            check("m1_valid", out_valid1, q1.size() > 0);
            check("m1_ctrl",  out_ctrl1,  (q1.size() > 0) ? q1[0].c : BUB1);
            check("m1_data",  out_data1,  (q1.size() > 0) ? q1[0].d : last1);
            check("m1_occ",   occ1,       q1.size());
            check("m1_ready", in_ready1,  q1.size() < 2);
            check("m1_rdy_implies", in_ready1 | (occ1 == 2'd2), 1'b1);
            check("m0_valid", out_valid0, q0.size() > 0);
            check("m0_ctrl",  out_ctrl0,  (q0.size() > 0) ? q0[0].c : BUB0);
            check("m0_data",  out_data0,  (q0.size() > 0) ? q0[0].d : last0);
            check("m0_occ",   occ0,       q0.size());
            check("m0_ready", in_ready0,  (q0.size() == 0) || out_ready);
        end
    end

    task automatic cyc(input bit r, input bit f, input bit iv,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input bit ordy);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;

        cyc(1, 0, 0, '0, '0, 0);
        cyc(1, 0, 0, '0, '0, 0);
        chk_en = 1;
        check("rst_ctrl1", out_ctrl1, 17'h1ABCD);
        check("rst_data1", out_data1, 32'h0);
        check("rst_occ1",  occ1, 2'd0);
        check("rst_rdy1",  in_ready1, 1'b1);
        check("rst_rdy0",  in_ready0, 1'b1);

        // Streaming 1..10 with no backpressure
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 0, 1, CW'(i), DW'(i), 1);
            check("stream_data", out_data1, DW'(i));
            check("stream_occ",  occ1, 2'd1);
        end
        cyc(0, 0, 0, '0, '0, 1);
        check("stream_end_valid", out_valid1, 1'b0);
        check("stream_end_data",  out_data1, 32'h0000000A);

        // Backpressure: A then B held, then released in order
        cyc(0, 0, 1, 17'h00011, 32'hAAAA0001, 0);
        check("bp_occ_a", occ1, 2'd1);
        cyc(0, 0, 1, 17'h00022, 32'hBBBB0002, 0);
        check("bp_occ_b",  occ1, 2'd2);
        check("bp_rdy_b",  in_ready1, 1'b0);
        check("bp_data_a", out_data1, 32'hAAAA0001);
        cyc(0, 0, 0, '0, '0, 0);
        check("bp_stall_data", out_data1, 32'hAAAA0001);
        check("bp_stall_ctrl", out_ctrl1, 17'h00011);
        cyc(0, 0, 0, '0, '0, 1);
        check("bp_rel_data", out_data1, 32'hBBBB0002);
        check("bp_rel_occ",  occ1, 2'd1);
        check("bp_rel_rdy",  in_ready1, 1'b1);
        cyc(0, 0, 0, '0, '0, 1);
        check("bp_empty_ctrl", out_ctrl1, 17'h1ABCD);

        // Flush while two entries held, with a concurrent offer of C
        cyc(0, 0, 1, 17'h00044, 32'hAAAA0004, 0);
        cyc(0, 0, 1, 17'h00045, 32'hBBBB0005, 0);
        check("fl_pre_occ", occ1, 2'd2);
        cyc(0, 1, 1, 17'h00033, 32'hCCCC0003, 0);
        check("fl_valid", out_valid1, 1'b0);
        check("fl_ctrl",  out_ctrl1, 17'h1ABCD);
        check("fl_occ",   occ1, 2'd0);
        check("fl_data",  out_data1, 32'hAAAA0004);
        check("fl_rdy",   in_ready1, 1'b1);
        cyc(0, 0, 0, '0, '0, 1);
        cyc(0, 0, 0, '0, '0, 1);

        // Reset mid-operation with an offer present
        cyc(0, 0, 1, 17'h00046, 32'hAAAA0006, 0);
        cyc(0, 0, 1, 17'h00047, 32'hBBBB0007, 0);
        cyc(1, 0, 1, 17'h00048, 32'hEEEE0008, 0);
        check("mr_occ",  occ1, 2'd0);
        check("mr_data", out_data1, 32'h0);
        check("mr_ctrl", out_ctrl1, 17'h1ABCD);
        check("mr_rdy",  in_ready1, 1'b1);
        cyc(0, 0, 1, 17'h00055, 32'h55550006, 1);
        check("mr_next_data", out_data1, 32'h55550006);
        check("mr_next_occ",  occ1, 2'd1);
        cyc(0, 0, 0, '0, '0, 1);
        check("mr_drained", occ1, 2'd0);

        // SKID=0: stall gives combinational in_ready=0, release reloads with no bubble
        cyc(0, 0, 1, 17'h00066, 32'hF0F00007, 0);
        check("s0_occ",   occ0, 2'd1);
        check("s0_stall_rdy", in_ready0, 1'b0);
        in_valid  = 1'b1;
        in_ctrl   = 17'h00077;
        in_data   = 32'hD00D0008;
        out_ready = 1'b1;
        #1;
        check("s0_comb_rdy", in_ready0, 1'b1);
        @(posedge sysclk);
        #1;
        check("s0_reload_data",  out_data0, 32'hD00D0008);
        check("s0_reload_valid", out_valid0, 1'b1);
        cyc(0, 1, 1, 17'h00099, 32'h99990009, 0);
        check("s0_fl_ctrl", out_ctrl0, 17'h0);
        check("s0_fl_data", out_data0, 32'hD00D0008);
        check("s1_fl_ctrl", out_ctrl1, 17'h1ABCD);
        cyc(0, 0, 0, '0, '0, 1);
        cyc(0, 0, 0, '0, '0, 1);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
